spi_arb: RTL and testbench

SPI_ARB -- requirements
Module: spi_arb

---
 rtl/spi_arb.sv | 106 ++++++++++
 tb/tb_spi_arb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arb.sv
// rtl/spi_arb.sv - two-client round-robin arbiter in front of a single SPI monarch
// One transaction in flight at a time; abandoned with err=1 and rsp=FFFF if the monarch stalls.
module spi_arb #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] cmd0,
    input  logic        req1,
    input  logic [15:0] cmd1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rsp,
    output logic        err,
    output logic        busy,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [1:0]  state;
    logic        id;
    logic        last;
    logic [15:0] cnt;
    logic        grant_id;

    // On a tie the client that was not served last wins; otherwise the lone requester.
    always_comb begin
        grant_id = req1;
        if (req0 && req1) begin
            grant_id = ~last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            id      <= 1'b0;
            last    <= 1'b1;
            cnt     <= 16'h0000;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rsp     <= 16'h0000;
            err     <= 1'b0;
            busy    <= 1'b0;
            spi_wrt <= 1'b0;
            spi_cmd <= 16'h0000;
        end else begin
            spi_wrt <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        id      <= grant_id;
                        spi_cmd <= grant_id ? cmd1 : cmd0;
                        spi_wrt <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt   <= 16'h0000;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion is checked first so a done on the timeout cycle still succeeds.
                    if (spi_done) begin
                        rsp   <= spi_rd_data;
                        err   <= 1'b0;
                        ack0  <= ~id;
                        ack1  <= id;
                        state <= S_RESP;
                    end else if (cnt >= TO_LAST) begin
                        rsp   <= 16'hFFFF;
                        err   <= 1'b1;
                        ack0  <= ~id;
                        ack1  <= id;
                        state <= S_RESP;
                    end else if (cnt != 16'hFFFF) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    last  <= id;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arb.sv
// tb/tb_spi_arb.sv - directed self-checking bench for spi_arb
// Instance a uses the default timeout, instance b uses TIMEOUT_CYC=8.
module tb_spi_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, spi_done;
    logic [15:0] cmd0, cmd1, spi_rd_data;
    logic        ack0, ack1, err, busy, spi_wrt;
    logic [15:0] rsp, spi_cmd;

    logic        b_req0, b_req1, b_spi_done;
    logic [15:0] b_cmd0, b_cmd1, b_spi_rd_data;
    logic        b_ack0, b_ack1, b_err, b_busy, b_spi_wrt;
    logic [15:0] b_rsp, b_spi_cmd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_arb u_a (
        .clk(clk), .rst(rst),
        .req0(req0), .cmd0(cmd0), .req1(req1), .cmd1(cmd1),
        .ack0(ack0), .ack1(ack1), .rsp(rsp), .err(err), .busy(busy),
        .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
        .spi_done(spi_done), .spi_rd_data(spi_rd_data)
    );

    spi_arb #(.TIMEOUT_CYC(8)) u_b (
        .clk(clk), .rst(rst),
        .req0(b_req0), .cmd0(b_cmd0), .req1(b_req1), .cmd1(b_cmd1),
        .ack0(b_ack0), .ack1(b_ack1), .rsp(b_rsp), .err(b_err), .busy(b_busy),
        .spi_wrt(b_spi_wrt), .spi_cmd(b_spi_cmd),
        .spi_done(b_spi_done), .spi_rd_data(b_spi_rd_data)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_wrt(input string tag);
        int n = 0;
        while (spi_wrt !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {15'd0, spi_wrt}, 16'd1);
    endtask

    task automatic b_wait_wrt(input string tag);
        int n = 0;
        while (b_spi_wrt !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {15'd0, b_spi_wrt}, 16'd1);
    endtask

    // Waits for the launch, completes after dly cycles and checks the ack.
    task automatic serve(input string tag, input logic id, input logic [15:0] ecmd,
                         input logic [15:0] rd, input int dly);
        wait_wrt({tag, "_wrt"});
        chk({tag, "_cmd"}, spi_cmd, ecmd);
        repeat (dly) @(negedge clk);
        spi_done = 1'b1;
        spi_rd_data = rd;
        @(negedge clk);
        spi_done = 1'b0;
        chk({tag, "_ack0"}, {15'd0, ack0}, {15'd0, ~id});
        chk({tag, "_ack1"}, {15'd0, ack1}, {15'd0, id});
        chk({tag, "_rsp"}, rsp, rd);
        chk({tag, "_err"}, {15'd0, err}, 16'd0);
    endtask

    initial begin
        int acks;
        rst = 1'b1;
        req0 = 0; req1 = 0; cmd0 = 0; cmd1 = 0; spi_done = 0; spi_rd_data = 0;
        b_req0 = 0; b_req1 = 0; b_cmd0 = 0; b_cmd1 = 0; b_spi_done = 0; b_spi_rd_data = 0;
        #1;
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_wrt", {15'd0, spi_wrt}, 16'd0);
        chk("rst_rsp", rsp, 16'h0000);
        chk("rst_cmd", spi_cmd, 16'h0000);
        chk("rst_acks", {14'd0, ack1, ack0}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single request with a slow monarch
        @(negedge clk);
        req0 = 1'b1; cmd0 = 16'hA5C3;
        @(negedge clk);
        chk("single_wrt_lat", {15'd0, spi_wrt}, 16'd1);
        chk("single_cmd", spi_cmd, 16'hA5C3);
        chk("single_busy", {15'd0, busy}, 16'd1);
        @(negedge clk);
        chk("single_wrt_pulse", {15'd0, spi_wrt}, 16'd0);
        acks = 0;
        repeat (38) begin
            @(negedge clk);
            acks += int'(ack0) + int'(ack1);
        end
        chk("single_no_early_ack", 16'(acks), 16'd0);
        spi_done = 1'b1; spi_rd_data = 16'h1234;
        @(negedge clk);
        spi_done = 1'b0; req0 = 1'b0;
        chk("single_ack0", {15'd0, ack0}, 16'd1);
        chk("single_ack1", {15'd0, ack1}, 16'd0);
        chk("single_rsp", rsp, 16'h1234);
        chk("single_err", {15'd0, err}, 16'd0);
        @(negedge clk);
        chk("single_ack_1cyc", {15'd0, ack0}, 16'd0);
        chk("single_idle", {15'd0, busy}, 16'd0);
        chk("single_rsp_hold", rsp, 16'h1234);
        chk("single_cmd_hold", spi_cmd, 16'hA5C3);

        // Tie from reset: 0, 1, 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; cmd0 = 16'h1111; cmd1 = 16'h2222;
        serve("tie1", 1'b0, 16'h1111, 16'h0A0A, 2);
        serve("tie2", 1'b1, 16'h2222, 16'h0B0B, 3);
        serve("tie3", 1'b0, 16'h1111, 16'h0C0C, 1);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Stray done in IDLE and in LAUNCH
        spi_done = 1'b1; spi_rd_data = 16'hDEAD;
        @(negedge clk);
        spi_done = 1'b0;
        chk("stray_idle_ack", {14'd0, ack1, ack0}, 16'd0);
        chk("stray_idle_busy", {15'd0, busy}, 16'd0);
        chk("stray_idle_rsp", rsp, 16'h0C0C);
        req1 = 1'b1; cmd1 = 16'hBEEF;
        @(negedge clk);
        chk("stray_launch_wrt", {15'd0, spi_wrt}, 16'd1);
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        chk("stray_launch_ack", {14'd0, ack1, ack0}, 16'd0);
        chk("stray_launch_busy", {15'd0, busy}, 16'd1);
        repeat (3) @(negedge clk);
        spi_done = 1'b1; spi_rd_data = 16'h5555;
        @(negedge clk);
        spi_done = 1'b0; req1 = 1'b0;
        chk("stray_ack1", {15'd0, ack1}, 16'd1);
        chk("stray_rsp", rsp, 16'h5555);
        @(negedge clk);

        // Reset in the middle of WAIT
        req0 = 1'b1; cmd0 = 16'h7777;
        wait_wrt("rstmid_wrt");
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_busy", {15'd0, busy}, 16'd0);
        chk("rstmid_rsp", rsp, 16'h0000);
        chk("rstmid_cmd", spi_cmd, 16'h0000);
        chk("rstmid_errwrt", {14'd0, err, spi_wrt}, 16'd0);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        spi_done = 1'b1; spi_rd_data = 16'h9999;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            spi_done = 1'b0;
            acks += int'(ack0) + int'(ack1);
        end
        chk("rstmid_no_ack", 16'(acks), 16'd0);
        chk("rstmid_rsp_after", rsp, 16'h0000);

        // Timeout with TIMEOUT_CYC=8
        b_req1 = 1'b1; b_cmd1 = 16'h0C0C;
        b_wait_wrt("to_wrt");
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            acks += int'(b_ack0) + int'(b_ack1);
        end
        chk("to_no_early_ack", 16'(acks), 16'd0);
        @(negedge clk);
        b_req1 = 1'b0;
        chk("to_ack1", {15'd0, b_ack1}, 16'd1);
        chk("to_ack0", {15'd0, b_ack0}, 16'd0);
        chk("to_err", {15'd0, b_err}, 16'd1);
        chk("to_rsp", b_rsp, 16'hFFFF);
        @(negedge clk);
        chk("to_err_hold", {15'd0, b_err}, 16'd1);
        b_req0 = 1'b1; b_cmd0 = 16'h0101;
        b_wait_wrt("to_next_wrt");
        chk("to_next_cmd", b_spi_cmd, 16'h0101);
        repeat (2) @(negedge clk);
        b_spi_done = 1'b1; b_spi_rd_data = 16'hABCD;
        @(negedge clk);
        b_spi_done = 1'b0; b_req0 = 1'b0;
        chk("to_next_ack0", {15'd0, b_ack0}, 16'd1);
        chk("to_next_err", {15'd0, b_err}, 16'd0);
        chk("to_next_rsp", b_rsp, 16'hABCD);
        @(negedge clk);

        // Done coinciding with the timeout cycle
        b_req1 = 1'b1; b_cmd1 = 16'h4242;
        b_wait_wrt("edge_wrt");
        repeat (8) @(negedge clk);
        chk("edge_no_early_ack", {14'd0, b_ack1, b_ack0}, 16'd0);
        b_spi_done = 1'b1; b_spi_rd_data = 16'h00FF;
        @(negedge clk);
        b_spi_done = 1'b0; b_req1 = 1'b0;
        chk("edge_ack1", {15'd0, b_ack1}, 16'd1);
        chk("edge_err", {15'd0, b_err}, 16'd0);
        chk("edge_rsp", b_rsp, 16'h00FF);
        @(negedge clk);
        chk("edge_ack_1cyc", {14'd0, b_ack1, b_ack0}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
